// File: rtl/cacheline_adaptor.sv
// Cacheline <-> 4-beat burst adaptor; line_resp_o BEATS+1 cycles after request with back-to-back beats.
// Burst wait states (burst_resp_i low) stall the FSM; optional watchdog under CLA_TIMEOUT_EN.
module cacheline_adaptor #(
    parameter int LINE_W         = 256,
    parameter int BURST_W        = 64,
    parameter int OFFSET_W       = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         line_address_i,
    input  logic                line_read_i,
    input  logic                line_write_i,
    input  logic [LINE_W-1:0]   line_wdata_i,
    output logic [LINE_W-1:0]   line_rdata_o,
    output logic                line_resp_o,
    output logic [31:0]         burst_address_o,
    output logic                burst_read_o,
    output logic                burst_write_o,
    output logic [BURST_W-1:0]  burst_wdata_o,
    input  logic [BURST_W-1:0]  burst_rdata_i,
    input  logic                burst_resp_i,
    output logic                err_o
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LINE_W-1:0]   r_wbuf;
    logic [LINE_W-1:0]   r_rdata;
    logic                r_resp;
    logic                r_bread;
    logic                r_bwrite;
    logic [31:0]         r_baddr;
    logic [BURST_W-1:0]  r_bwdata;

    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_last;
    logic                w_wdog_exp;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_last    = (r_cnt == CNT_W'(BEATS - 1));

`ifdef CLA_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WDOG_W-1:0]   r_wdog;
    logic                r_err;
    logic                w_busy;

    assign w_busy     = (r_state == READ) || (r_state == WRITE);
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a beat.
    assign w_wdog_exp = w_busy && !burst_resp_i && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign err_o      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (!w_busy || burst_resp_i || w_wdog_exp)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 1'b1;
            if (w_wdog_exp)
                r_err <= 1'b1;
        end
    end
`else
    assign w_wdog_exp = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wbuf   <= '0;
            r_rdata  <= '0;
            r_resp   <= 1'b0;
            r_bread  <= 1'b0;
            r_bwrite <= 1'b0;
            r_baddr  <= '0;
            r_bwdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (line_write_i) begin
                        r_baddr  <= line_address_i & ADDR_MASK;
                        r_wbuf   <= line_wdata_i;
                        r_bwdata <= line_wdata_i[BURST_W-1:0];
                        r_cnt    <= '0;
                        r_bwrite <= 1'b1;
                        r_state  <= WRITE;
                    end else if (line_read_i) begin
                        r_baddr  <= line_address_i & ADDR_MASK;
                        r_cnt    <= '0;
                        r_bread  <= 1'b1;
                        r_state  <= READ;
                    end
                end
                READ: begin
                    if (burst_resp_i) begin
                        r_rdata[BURST_W*r_cnt +: BURST_W] <= burst_rdata_i;
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_bread <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end
                    end else if (w_wdog_exp) begin
                        r_bread <= 1'b0;
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                WRITE: begin
                    if (burst_resp_i) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_bwrite <= 1'b0;
                            r_resp   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_bwdata <= r_wbuf[BURST_W*w_cnt_nxt +: BURST_W];
                        end
                    end else if (w_wdog_exp) begin
                        r_bwrite <= 1'b0;
                        r_resp   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_resp  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign line_rdata_o    = r_rdata;
    assign line_resp_o     = r_resp;
    assign burst_address_o = r_baddr;
    assign burst_read_o    = r_bread;
    assign burst_write_o   = r_bwrite;
    assign burst_wdata_o   = r_bwdata;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor; the watchdog case runs only when CLA_TIMEOUT_EN is defined.
module tb_cacheline_adaptor;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [31:0]         line_address_i;
    logic                line_read_i;
    logic                line_write_i;
    logic [LINE_W-1:0]   line_wdata_i;
    logic [LINE_W-1:0]   line_rdata_o;
    logic                line_resp_o;
    logic [31:0]         burst_address_o;
    logic                burst_read_o;
    logic                burst_write_o;
    logic [BURST_W-1:0]  burst_wdata_o;
    logic [BURST_W-1:0]  burst_rdata_i;
    logic                burst_resp_i;
    logic                err_o;

    always #5 clk = ~clk;

    cacheline_adaptor #(
        .LINE_W(LINE_W), .BURST_W(BURST_W), .OFFSET_W(5), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .line_address_i(line_address_i), .line_read_i(line_read_i),
        .line_write_i(line_write_i), .line_wdata_i(line_wdata_i),
        .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
        .burst_address_o(burst_address_o), .burst_read_o(burst_read_o),
        .burst_write_o(burst_write_o), .burst_wdata_o(burst_wdata_o),
        .burst_rdata_i(burst_rdata_i), .burst_resp_i(burst_resp_i),
        .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read with back-to-back beats; request in cycle C0, resp expected in C5.
    task automatic read_line(input logic [31:0] addr, input logic [31:0] exp_addr,
                             input logic [255:0] line, input bit stray_in_done, input string tag);
        @(negedge clk);
        line_read_i    = 1'b1;
        line_address_i = addr;
        @(negedge clk);
        check({tag, "_addr"}, 256'(burst_address_o), 256'(exp_addr));
        for (int k = 0; k < 4; k++) begin
            check({tag, "_rdreq"}, 256'(burst_read_o), 256'(1));
            check({tag, "_noresp"}, 256'(line_resp_o), 256'(0));
            burst_resp_i  = 1'b1;
            burst_rdata_i = line[64*k +: 64];
            @(negedge clk);
        end
        burst_resp_i = stray_in_done;
        burst_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        check({tag, "_resp"}, 256'(line_resp_o), 256'(1));
        check({tag, "_rddrop"}, 256'(burst_read_o), 256'(0));
        check({tag, "_line"}, line_rdata_o, line);
        @(negedge clk);
        line_read_i  = 1'b0;
        burst_resp_i = 1'b0;
        check({tag, "_resp1cyc"}, 256'(line_resp_o), 256'(0));
        check({tag, "_hold"}, line_rdata_o, line);
    endtask

    logic [255:0] line_a, line_b, line_c, wline, prev;
    logic [63:0]  wexp [6];
    bit           wrsp [6];
    int           cyc;

    initial begin
        rst_n = 1'b0; line_address_i = '0; line_read_i = 1'b0; line_write_i = 1'b0;
        line_wdata_i = '0; burst_rdata_i = '0; burst_resp_i = 1'b0;
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_b = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
                  64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
        line_c = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                  64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
        wline  = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                  64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        #12;
        check("rst_rdata", line_rdata_o, '0);
        check("rst_outs", {burst_address_o, burst_wdata_o, line_resp_o, burst_read_o,
                           burst_write_o, err_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        read_line(32'h0000_1234, 32'h0000_1220, line_a, 1'b0, "rd1");

        // Write with two wait cycles before beat 2.
        wexp = '{64'hD0D0_D0D0_D0D0_D0D0, 64'hD1D1_D1D1_D1D1_D1D1, 64'hD2D2_D2D2_D2D2_D2D2,
                 64'hD2D2_D2D2_D2D2_D2D2, 64'hD2D2_D2D2_D2D2_D2D2, 64'hD3D3_D3D3_D3D3_D3D3};
        wrsp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        line_write_i = 1'b1; line_address_i = 32'hABCD_EF7F; line_wdata_i = wline;
        @(negedge clk);
        check("wr_addr", 256'(burst_address_o), 256'(32'hABCD_EF60));
        for (int i = 0; i < 6; i++) begin
            check("wr_req", 256'(burst_write_o), 256'(1));
            check("wr_data", 256'(burst_wdata_o), 256'(wexp[i]));
            check("wr_noresp", 256'(line_resp_o), 256'(0));
            burst_resp_i = wrsp[i];
            @(negedge clk);
        end
        burst_resp_i = 1'b0;
        check("wr_resp", 256'(line_resp_o), 256'(1));
        check("wr_drop", 256'(burst_write_o), 256'(0));
        @(negedge clk);
        line_write_i = 1'b0;
        check("wr_resp1cyc", 256'(line_resp_o), 256'(0));

        // Both requests high: write wins, read line untouched.
        @(negedge clk);
        line_write_i = 1'b1; line_read_i = 1'b1; line_address_i = 32'h0000_0080;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("both_wr", 256'(burst_write_o), 256'(1));
            check("both_nord", 256'(burst_read_o), 256'(0));
            burst_resp_i = 1'b1;
            @(negedge clk);
        end
        burst_resp_i = 1'b0;
        check("both_resp", 256'(line_resp_o), 256'(1));
        check("both_nord_done", 256'(burst_read_o), 256'(0));
        check("both_rdata", line_rdata_o, line_a);
        @(negedge clk);
        line_write_i = 1'b0; line_read_i = 1'b0;

        // Reset after beat 1 of a read.
        prev = line_a;
        @(negedge clk);
        line_read_i = 1'b1; line_address_i = 32'h0000_0040;
        @(negedge clk);
        burst_resp_i = 1'b1; burst_rdata_i = line_c[63:0];
        @(negedge clk);
        burst_rdata_i = line_c[127:64];
        @(negedge clk);
        burst_resp_i = 1'b0;
        check("partial", line_rdata_o, {prev[255:128], line_c[127:0]});
        rst_n = 1'b0;
        #1;
        check("arst_rdata", line_rdata_o, '0);
        check("arst_outs", {burst_address_o, burst_wdata_o, line_resp_o, burst_read_o,
                            burst_write_o, err_o}, '0);
        line_read_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        read_line(32'h0000_0040, 32'h0000_0040, line_b, 1'b0, "rd_post_rst");

        // Stray beats in IDLE must be ignored; stray beat in DONE must not alter the line.
        @(negedge clk);
        burst_resp_i = 1'b1; burst_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        burst_resp_i = 1'b0;
        check("stray_noresp", 256'(line_resp_o), 256'(0));
        check("stray_nordreq", 256'(burst_read_o), 256'(0));
        check("stray_line", line_rdata_o, line_b);
        read_line(32'hFFFF_FFFF, 32'hFFFF_FFE0, line_c, 1'b1, "rd_stray");

`ifdef CLA_TIMEOUT_EN
        // Request in C0, 16 stalled READ cycles (C1..C16), resp in C17.
        @(negedge clk);
        line_read_i = 1'b1; line_address_i = 32'h0000_2000;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!line_resp_o && cyc < 64);
        check("to_latency", 256'(cyc), 256'(17));
        check("to_err", 256'(err_o), 256'(1));
        check("to_drop", 256'(burst_read_o), 256'(0));
        check("to_line", line_rdata_o, line_c);
        @(negedge clk);
        line_read_i = 1'b0;
        @(negedge clk);
        check("to_sticky", 256'(err_o), 256'(1));
        check("to_resp1cyc", 256'(line_resp_o), 256'(0));
        rst_n = 1'b0;
        #1;
        check("to_err_clr", 256'(err_o), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
`else
        cyc = 0;
        check("no_err", 256'(err_o), 256'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
